ov5640_cfg_seq: RTL and testbench

- Register-table sequencer that sits directly upstream of the team's I2C master, in the OV5640 configuration path.
- After power-up or a start pulse, it fetches {reg_addr[15:0], data[7:0]} entries from an external synchronous ROM.
- Each entry becomes a 4-byte I2C write (device address, address high byte, address low byte, data), issued through the master's iic_req/iic_busy/iic_bus_error handshake.
- Handles table delay entries, per-entry retry on NACK, and reports done or error status to the system.

---
 rtl/ov5640_cfg_seq.sv | 168 ++++++++++++++++
 tb/tb_ov5640_cfg_seq.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov5640_cfg_seq.sv
// OV5640 register-table sequencer: walks a synchronous ROM of {reg_addr, data}
// entries and turns each one into a 4-byte I2C write through the I2C master.
module ov5640_cfg_seq #(
  parameter logic [7:0]  DEV_ADDR  = 8'h78,
  parameter logic [9:0]  REG_NUM   = 10'd256,
  parameter logic [23:0] PWR_DLY   = 24'd1_000_000,
  parameter logic [16:0] MS_CYC    = 17'd100_000,
  parameter logic [3:0]  RETRY_MAX = 4'd3,
  parameter logic [19:0] ACK_TMO   = 20'd500_000
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cfg_start_i,
  output logic [9:0]  tab_addr_o,
  input  logic [23:0] tab_data_i,
  output logic [31:0] iic_wr_data_o,
  output logic [7:0]  iic_wr_cnt_o,
  output logic [7:0]  iic_rd_cnt_o,
  output logic        iic_mode_o,
  output logic        iic_req_o,
  input  logic        iic_busy_i,
  input  logic        iic_bus_error_i,
  output logic        cfg_done_o,
  output logic        cfg_error_o,
  output logic [9:0]  cfg_idx_o
);

  localparam logic [3:0] ST_PWR_WAIT = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_LOAD     = 4'd2;
  localparam logic [3:0] ST_REQ      = 4'd3;
  localparam logic [3:0] ST_BUSY     = 4'd4;
  localparam logic [3:0] ST_ERR_WAIT = 4'd5;
  localparam logic [3:0] ST_DELAY    = 4'd6;
  localparam logic [3:0] ST_NEXT     = 4'd7;
  localparam logic [3:0] ST_DONE     = 4'd8;
  localparam logic [3:0] ST_FAIL     = 4'd9;

  logic [3:0]  state;
  logic [9:0]  idx;
  logic [23:0] pwr_cnt;
  logic [24:0] dly_cnt;
  logic [19:0] tmo_cnt;
  logic [3:0]  retry;
  logic        err_flag;
  logic [31:0] wr_data;
  logic        busy_meta, busy_s;
  logic        err_meta, err_s;

  // busy/bus_error come from the master's SCL-divided domain
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      busy_meta <= 1'b0;
      busy_s    <= 1'b0;
      err_meta  <= 1'b0;
      err_s     <= 1'b0;
    end else begin
      busy_meta <= iic_busy_i;
      busy_s    <= busy_meta;
      err_meta  <= iic_bus_error_i;
      err_s     <= err_meta;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state    <= ST_PWR_WAIT;
      idx      <= '0;
      pwr_cnt  <= '0;
      dly_cnt  <= '0;
      tmo_cnt  <= '0;
      retry    <= '0;
      err_flag <= 1'b0;
      wr_data  <= '0;
    end else begin
      case (state)
        ST_PWR_WAIT: begin
          if ({1'b0, pwr_cnt} + 25'd1 >= {1'b0, PWR_DLY}) begin
            idx   <= '0;
            state <= ST_FETCH;
          end else begin
            pwr_cnt <= pwr_cnt + 24'd1;
          end
        end
        ST_FETCH: state <= ST_LOAD;
        ST_LOAD: begin
          if (tab_data_i[23:8] == 16'hFFFF) begin
            if (tab_data_i[7:0] == 8'd0) begin
              state <= ST_NEXT;
            end else begin
              dly_cnt <= {17'd0, tab_data_i[7:0]} * {8'd0, MS_CYC};
              state   <= ST_DELAY;
            end
          end else begin
            wr_data <= {tab_data_i[7:0], tab_data_i[15:8], tab_data_i[23:16], DEV_ADDR};
            tmo_cnt <= '0;
            state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (busy_s) begin
            err_flag <= 1'b0;
            state    <= ST_BUSY;
          end else if ({1'b0, tmo_cnt} + 21'd1 >= {1'b0, ACK_TMO}) begin
            state <= ST_ERR_WAIT;
          end else begin
            tmo_cnt <= tmo_cnt + 20'd1;
          end
        end
        ST_BUSY: begin
          if (err_s) err_flag <= 1'b1;
          if (!busy_s) state <= (err_flag || err_s) ? ST_ERR_WAIT : ST_NEXT;
        end
        // Retry only once the master has fully released busy and its error flag
        ST_ERR_WAIT: begin
          if (!busy_s && !err_s) begin
            if (retry < RETRY_MAX) begin
              retry   <= retry + 4'd1;
              tmo_cnt <= '0;
              state   <= ST_REQ;
            end else begin
              state <= ST_FAIL;
            end
          end
        end
        ST_DELAY: begin
          if (dly_cnt == '0) state <= ST_NEXT;
          else dly_cnt <= dly_cnt - 25'd1;
        end
        ST_NEXT: begin
          retry <= '0;
          if (idx == REG_NUM - 10'd1) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 10'd1;
            state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          if (cfg_start_i) begin
            idx   <= '0;
            state <= ST_FETCH;
          end
        end
        ST_FAIL: begin
          if (cfg_start_i) begin
            idx   <= '0;
            retry <= '0;
            state <= ST_FETCH;
          end
        end
        default: state <= ST_PWR_WAIT;
      endcase
    end
  end

  // Request and status are decoded from state so an async reset drops them at once
  assign iic_req_o     = (state == ST_REQ);
  assign cfg_done_o    = (state == ST_DONE);
  assign cfg_error_o   = (state == ST_FAIL);
  assign tab_addr_o    = idx;
  assign cfg_idx_o     = idx;
  assign iic_wr_data_o = wr_data;
  assign iic_wr_cnt_o  = 8'd4;
  assign iic_rd_cnt_o  = 8'd0;
  assign iic_mode_o    = 1'b0;

endmodule

// File: tb/tb_ov5640_cfg_seq.sv
// Self-checking bench for ov5640_cfg_seq: ROM + I2C master models and a
// table-level reference model predicting requests, gaps and final status.
module tb_ov5640_cfg_seq;

  localparam logic [7:0]  DEV_ADDR  = 8'h78;
  localparam logic [9:0]  REG_NUM   = 10'd3;
  localparam logic [23:0] PWR_DLY   = 24'd20;
  localparam logic [16:0] MS_CYC    = 17'd10;
  localparam logic [3:0]  RETRY_MAX = 4'd3;
  localparam logic [19:0] ACK_TMO   = 20'd40;
  localparam int NENT = 3;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        cfg_start_i;
  logic [9:0]  tab_addr_o;
  logic [23:0] tab_data_i = 24'h0;
  logic [31:0] iic_wr_data_o;
  logic [7:0]  iic_wr_cnt_o, iic_rd_cnt_o;
  logic        iic_mode_o, iic_req_o;
  logic        iic_busy_i, iic_bus_error_i;
  logic        cfg_done_o, cfg_error_o;
  logic [9:0]  cfg_idx_o;

  ov5640_cfg_seq #(
    .DEV_ADDR(DEV_ADDR), .REG_NUM(REG_NUM), .PWR_DLY(PWR_DLY),
    .MS_CYC(MS_CYC), .RETRY_MAX(RETRY_MAX), .ACK_TMO(ACK_TMO)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cfg_start_i(cfg_start_i),
    .tab_addr_o(tab_addr_o), .tab_data_i(tab_data_i),
    .iic_wr_data_o(iic_wr_data_o), .iic_wr_cnt_o(iic_wr_cnt_o),
    .iic_rd_cnt_o(iic_rd_cnt_o), .iic_mode_o(iic_mode_o),
    .iic_req_o(iic_req_o), .iic_busy_i(iic_busy_i),
    .iic_bus_error_i(iic_bus_error_i), .cfg_done_o(cfg_done_o),
    .cfg_error_o(cfg_error_o), .cfg_idx_o(cfg_idx_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [23:0] rom [NENT];
  int nack_plan [NENT];
  int nack_left [NENT];
  bit no_busy = 1'b0;
  int busy_fall_cyc = 0;

  logic [31:0] obs_word[$];
  int obs_gap[$];
  int obs_len[$];
  logic [31:0] exp_word[$];
  int exp_lo[$];
  int exp_hi[$];
  bit exp_fail;
  int exp_idx;

  always @(posedge clk_i) cyc <= cyc + 1;

  // synchronous ROM, one cycle of read latency
  always @(posedge clk_i)
    tab_data_i <= (int'(tab_addr_o) < NENT) ? rom[int'(tab_addr_o)] : 24'h0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int findEntry(input logic [31:0] w);
    for (int i = 0; i < NENT; i++)
      if (rom[i][23:8] != 16'hFFFF &&
          {rom[i][7:0], rom[i][15:8], rom[i][23:16], DEV_ADDR} == w) return i;
    return -1;
  endfunction

  // I2C master model: accepts a request, holds busy, optionally flags a NACK
  initial begin
    iic_busy_i = 1'b0;
    iic_bus_error_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      if (iic_req_o && !no_busy && rstn_i) begin
        int ent;
        bit nack;
        ent = findEntry(iic_wr_data_o);
        nack = 1'b0;
        if (ent >= 0 && nack_left[ent] > 0) begin
          nack_left[ent]--;
          nack = 1'b1;
        end
        repeat ($urandom_range(0, 2)) begin @(posedge clk_i); #1; end
        iic_busy_i = 1'b1;
        for (int k = 0; k < 100 && iic_req_o; k++) begin @(posedge clk_i); #1; end
        repeat ($urandom_range(1, 4)) begin @(posedge clk_i); #1; end
        if (nack) begin
          iic_bus_error_i = 1'b1;
          repeat (3) begin @(posedge clk_i); #1; end
          iic_bus_error_i = 1'b0;
        end
        repeat ($urandom_range(2, 4)) begin @(posedge clk_i); #1; end
        iic_busy_i = 1'b0;
        busy_fall_cyc = cyc;
      end
    end
  end

  // request monitor: word at each rising edge, gap since last busy fall, high time
  logic req_q = 1'b0;
  int rise_cyc = 0;
  always @(negedge clk_i) begin
    if (iic_req_o && !req_q) begin
      obs_word.push_back(iic_wr_data_o);
      obs_gap.push_back(cyc - busy_fall_cyc);
      rise_cyc = cyc;
    end
    if (!iic_req_o && req_q) obs_len.push_back(cyc - rise_cyc);
    req_q = iic_req_o;
  end

  // Reference model: walk the table, expanding NACK/timeout retries and
  // accumulating millisecond delays into the required request spacing.
  task automatic buildExpected(input bit tmo);
    int pend, ndly, tries;
    bit first;
    logic [15:0] a;
    logic [7:0] d;
    exp_word.delete(); exp_lo.delete(); exp_hi.delete();
    pend = 0; ndly = 0; first = 1'b1;
    exp_fail = 1'b0; exp_idx = NENT - 1;
    for (int i = 0; i < NENT; i++) begin
      a = rom[i][23:8];
      d = rom[i][7:0];
      if (a == 16'hFFFF) begin
        pend += int'(d) * int'(MS_CYC);
        ndly++;
        continue;
      end
      if (tmo || nack_plan[i] > int'(RETRY_MAX)) tries = int'(RETRY_MAX) + 1;
      else tries = nack_plan[i] + 1;
      for (int t = 0; t < tries; t++) begin
        exp_word.push_back({d, a[7:0], a[15:8], DEV_ADDR});
        if (first || tmo) begin
          exp_lo.push_back(-1); exp_hi.push_back(-1);
        end else if (t == 0) begin
          exp_lo.push_back(pend); exp_hi.push_back(pend + 8 + 4 * ndly);
        end else begin
          exp_lo.push_back(0); exp_hi.push_back(8);
        end
        first = 1'b0;
      end
      pend = 0; ndly = 0;
      if (tmo || nack_plan[i] > int'(RETRY_MAX)) begin
        exp_fail = 1'b1;
        exp_idx = i;
        break;
      end
    end
  endtask

  task automatic applyStimulus(input string name, input bit tmo, input bit via_reset, input bit poke);
    bit poked;
    int k;
    for (int i = 0; i < NENT; i++) nack_left[i] = nack_plan[i];
    no_busy = tmo;
    buildExpected(tmo);
    obs_word.delete(); obs_gap.delete(); obs_len.delete();
    if (via_reset) begin
      rstn_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rstn_i = 1'b1;
    end else begin
      @(posedge clk_i); #1 cfg_start_i = 1'b1;
      @(posedge clk_i); #1 cfg_start_i = 1'b0;
    end
    checkOutput($sformatf("%s:start_idx", name), cfg_idx_o, 0);
    checkOutput($sformatf("%s:start_done", name), cfg_done_o, 0);
    poked = 1'b0;
    for (k = 0; k < 5000; k++) begin
      @(negedge clk_i);
      if (cfg_done_o || cfg_error_o) break;
      if (poke && iic_busy_i && !poked) begin
        cfg_start_i = 1'b1;
        poked = 1'b1;
      end else begin
        cfg_start_i = 1'b0;
      end
    end
    cfg_start_i = 1'b0;
    checkOutput($sformatf("%s:finished", name), cfg_done_o | cfg_error_o, 1);
    repeat (30) @(negedge clk_i);
    checkOutput($sformatf("%s:done", name), cfg_done_o, !exp_fail);
    checkOutput($sformatf("%s:error", name), cfg_error_o, exp_fail);
    checkOutput($sformatf("%s:idx", name), cfg_idx_o, exp_idx);
    checkOutput($sformatf("%s:req_low", name), iic_req_o, 0);
    checkOutput($sformatf("%s:nreq", name), obs_word.size(), exp_word.size());
    for (int i = 0; i < obs_word.size() && i < exp_word.size(); i++) begin
      checkOutput($sformatf("%s:word%0d", name, i), obs_word[i], exp_word[i]);
      if (exp_lo[i] >= 0)
        checkOutput($sformatf("%s:gap%0d=%0d[%0d..%0d]", name, i, obs_gap[i], exp_lo[i], exp_hi[i]),
                    (obs_gap[i] >= exp_lo[i] && obs_gap[i] <= exp_hi[i]), 1);
    end
    if (tmo) begin
      checkOutput($sformatf("%s:nlen", name), obs_len.size(), int'(RETRY_MAX) + 1);
      foreach (obs_len[i]) checkOutput($sformatf("%s:req_len%0d", name, i), obs_len[i], int'(ACK_TMO));
    end
  endtask

  task automatic loadBase();
    rom[0] = 24'h3008_82;
    rom[1] = 24'h3103_11;
    rom[2] = 24'h3017_FF;
    for (int i = 0; i < NENT; i++) nack_plan[i] = 0;
  endtask

  initial begin
    int n;
    rstn_i = 1'b0;
    cfg_start_i = 1'b0;
    loadBase();
    repeat (3) @(posedge clk_i); #1;
    checkOutput("rst:req", iic_req_o, 0);
    checkOutput("rst:done", cfg_done_o, 0);
    checkOutput("rst:error", cfg_error_o, 0);
    checkOutput("rst:idx", cfg_idx_o, 0);
    checkOutput("rst:tab_addr", tab_addr_o, 0);
    checkOutput("rst:wr_data", iic_wr_data_o, 0);
    checkOutput("rst:wr_cnt", iic_wr_cnt_o, 4);
    checkOutput("rst:rd_cnt", iic_rd_cnt_o, 0);
    checkOutput("rst:mode", iic_mode_o, 0);

    $display("[TB] basic three-entry table");
    applyStimulus("A", 1'b0, 1'b1, 1'b0);
    if (obs_word.size() == 3) begin
      checkOutput("A:w0_const", obs_word[0], 32'h8208_3078);
      checkOutput("A:w1_const", obs_word[1], 32'h1103_3178);
      checkOutput("A:w2_const", obs_word[2], 32'hFF17_3078);
    end

    $display("[TB] 5 ms delay entry, restart from DONE");
    rom[1] = 24'hFFFF_05;
    applyStimulus("B", 1'b0, 1'b0, 1'b0);

    $display("[TB] zero delay entry");
    rom[1] = 24'hFFFF_00;
    applyStimulus("C", 1'b0, 1'b0, 1'b0);

    $display("[TB] two NACKs on entry 1, start pulse mid-transfer");
    loadBase();
    nack_plan[1] = 2;
    applyStimulus("D", 1'b0, 1'b0, 1'b1);
    n = 0;
    foreach (obs_word[i]) if (obs_word[i] == 32'h1103_3178) n++;
    checkOutput("D:e1_reqs", n, 3);

    $display("[TB] permanent NACK on entry 2");
    loadBase();
    nack_plan[2] = 15;
    applyStimulus("E", 1'b0, 1'b0, 1'b0);

    $display("[TB] busy never rises");
    loadBase();
    applyStimulus("F", 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NENT; i++) begin
        if ($urandom_range(0, 3) == 0) rom[i] = {16'hFFFF, 8'($urandom_range(0, 3))};
        else rom[i] = {8'($urandom_range(0, 254)), 8'(i), 8'($urandom_range(0, 255))};
        nack_plan[i] = $urandom_range(0, 4);
      end
      $display("[TB] random table %0d", r);
      applyStimulus($sformatf("R%0d", r), 1'b0, 1'b0, 1'b0);
    end

    loadBase();
    applyStimulus("H", 1'b0, 1'b0, 1'b0);
    rstn_i = 1'b0;
    #1;
    checkOutput("rdone:done", cfg_done_o, 0);
    checkOutput("rdone:idx", cfg_idx_o, 0);
    @(negedge clk_i) rstn_i = 1'b1;
    for (int k = 0; k < 200 && !iic_req_o; k++) @(negedge clk_i);
    checkOutput("rreq:seen", iic_req_o, 1);
    rstn_i = 1'b0;
    #1;
    checkOutput("rreq:req", iic_req_o, 0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;
    for (int k = 0; k < 200 && !iic_req_o; k++) @(negedge clk_i);
    for (int k = 0; k < 200 && !(iic_busy_i && !iic_req_o); k++) @(negedge clk_i);
    checkOutput("rbusy:seen", iic_busy_i, 1);
    rstn_i = 1'b0;
    #1;
    checkOutput("rbusy:req", iic_req_o, 0);
    checkOutput("rbusy:done", cfg_done_o, 0);
    repeat (2) @(negedge clk_i);
    applyStimulus("J", 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #800000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
